// File: rtl/tt_pin_sequencer.sv
// Host-side initiator for the tile's multiplexed pin protocol: drives ui/uio,
// waits a programmable settle time, samples uo and returns it on a response port.
module tt_pin_sequencer #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [5:0]       req_a,
  input  logic [5:0]       req_b,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [1:0]       rsp_mode,
  output logic [7:0]       pin_ui,
  output logic [7:0]       pin_uio,
  input  logic [7:0]       pin_uo,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_req_ready;
  logic             r_busy;
  logic [SW-1:0]    r_cnt;
  logic [7:0]       r_pin_ui;
  logic [7:0]       r_pin_uio;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic [1:0]       r_rsp_mode;
  logic [CNT_W-1:0] r_txn_count;
  logic             w_accept;
  logic             w_cnt_dec;
  logic             w_capture;
  logic             w_done;

  // State register; ready/busy are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (req_valid) w_state_nxt = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
      S_SETTLE:  if (r_cnt == SW'(1)) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP:    if (r_rsp_valid && rsp_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    w_accept  = 1'b0;
    w_cnt_dec = 1'b0;
    w_capture = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE:    w_accept  = req_valid;
      S_SETTLE:  w_cnt_dec = 1'b1;
      S_CAPTURE: w_capture = 1'b1;
      S_RESP:    w_done    = r_rsp_valid && rsp_ready;
      default:   w_accept  = 1'b0;
    endcase
  end

  // Pins change only on acceptance so tile latch state stays stable between ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_pin_ui    <= '0;
      r_pin_uio   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_mode  <= '0;
      r_txn_count <= '0;
    end else begin
      if (w_accept) begin
        r_pin_ui  <= {req_mode, req_a};
        r_pin_uio <= {req_cin, 1'b0, req_b};
        r_cnt     <= SW'(SETTLE);
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - SW'(1);
      end
      if (w_capture) begin
        r_rsp_data  <= pin_uo;
        r_rsp_mode  <= r_pin_ui[7:6];
        r_rsp_valid <= 1'b1;
      end else if (w_done) begin
        r_rsp_valid <= 1'b0;
        r_txn_count <= r_txn_count + CNT_W'(1);
      end
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_mode  = r_rsp_mode;
  assign pin_ui    = r_pin_ui;
  assign pin_uio   = r_pin_uio;
  assign txn_count = r_txn_count;

endmodule
